// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared defaults and small types for the PC/fetch unit.
//   - ADDR_W_DEF / DATA_W_DEF : default PC and instruction widths
//   - RESET_VEC_DEF           : PC value held while fetch is disabled
//   - PC_STEP_DEF             : sequential PC increment in bytes
//   - STALL_W_DEF / DEPTH_DEF : stall vector width, in-flight + buffered limit
//   - ce_e                    : fetch-enable encoding (ChipDisable/ChipEnable)
//   - NoStop                  : value of a stall bit that lets fetch proceed
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned ADDR_W_DEF    = 32;
   localparam int unsigned DATA_W_DEF    = 32;
   localparam logic [31:0] RESET_VEC_DEF = 32'h0040_0000;
   localparam int unsigned PC_STEP_DEF   = 4;
   localparam int unsigned STALL_W_DEF   = 6;
   localparam int unsigned DEPTH_DEF     = 4;

   typedef enum logic {
      ChipDisable = 1'b0,
      ChipEnable  = 1'b1
   } ce_e;

   localparam logic NoStop = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with synchronous clear. Head word is read
//   combinationally from the storage array, so a word written on one edge is
//   visible at data_o in the following cycle.
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous reset of pointers/count, active-high
//   push_i   in   1      write data_i (ignored when full or clearing)
//   pop_i    in   1      drop head word (ignored when empty or clearing)
//   clear_i  in   1      empty the FIFO; overrides push and pop
//   data_i   in   WIDTH  write data
//   data_o   out  WIDTH  head word (undefined content when empty)
//   count_o  out  CW     number of stored words
//   full_o   out  1      count_o == DEPTH
//   empty_o  out  1      count_o == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o & ~clear_i;
   assign do_pop  = pop_i & ~empty_o & ~clear_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         // Push and pop in the same cycle leave the count unchanged.
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers only.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Holds the fetch PC, applies flush/branch/stall redirects, issues pipelined
//   instruction-memory requests (req/gnt, in-order rvalid), discards responses
//   that belong to requests issued before a redirect, and buffers {pc,inst}
//   pairs for decode through a valid/ready interface.
// Ports
//   clk/rst           clock (rising edge), synchronous active-high reset
//   stall             stall vector; bit 0 freezes fetch
//   flush, new_pc     highest-priority redirect and its target
//   branch_flag_i     taken branch from decode (ignored while stall[0]=1)
//   branch_target_i   branch target
//   ce_o              fetch enable, rises the cycle after rst falls
//   pc_o              PC of the next request to issue
//   imem_req_o/_addr_o/_gnt_i       request handshake (addr = pc_o)
//   imem_rvalid_i/_rdata_i          in-order responses
//   inst_valid_o/inst_o/inst_pc_o   buffered head instruction and its PC
//   inst_ready_i      decode consumes head when valid & ready
// -----------------------------------------------------------------------------
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W    = ADDR_W_DEF,
   parameter int unsigned       DATA_W    = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
   parameter int unsigned       PC_STEP   = PC_STEP_DEF,
   parameter int unsigned       STALL_W   = STALL_W_DEF,
   parameter int unsigned       DEPTH     = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  new_pc,
   input  logic               branch_flag_i,
   input  logic [ADDR_W-1:0]  branch_target_i,
   output logic               ce_o,
   output logic [ADDR_W-1:0]  pc_o,
   output logic               imem_req_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic               imem_gnt_i,
   input  logic               imem_rvalid_i,
   input  logic [DATA_W-1:0]  imem_rdata_i,
   output logic               inst_valid_o,
   output logic [DATA_W-1:0]  inst_o,
   output logic [ADDR_W-1:0]  inst_pc_o,
   input  logic               inst_ready_i
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = CW + 2;

   ce_e               ce_q, ce_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CW-1:0]     out_q, out_d;     // granted, response still owed, live
   logic [CW-1:0]     drop_q, drop_d;   // granted before a redirect, to discard

   logic              ce_on, fetch_stall, branch_take, redirect;
   logic              credit_ok, grant, rsp_live, rsp_drop, inst_pop;

   logic [ADDR_W-1:0] a_head;
   logic [CW-1:0]     a_cnt, b_cnt;
   logic              a_full, a_empty, b_full, b_empty;
   logic [ADDR_W+DATA_W-1:0] b_head;

   assign ce_on       = (ce_q == ChipEnable);
   assign fetch_stall = (stall[0] != NoStop);
   assign branch_take = branch_flag_i & ~fetch_stall;
   assign redirect    = ce_on & (flush | branch_take);

   // Stale responses still occupy memory-side slots, so they count against
   // the credit alongside live requests and buffered instructions.
   assign credit_ok = (SW'(out_q) + SW'(drop_q) + SW'(b_cnt)) < SW'(DEPTH);

   assign imem_req_o  = ce_on & ~fetch_stall & ~flush & ~branch_flag_i & credit_ok;
   assign imem_addr_o = pc_q;
   assign pc_o        = pc_q;
   assign ce_o        = ce_on;
   assign grant       = imem_req_o & imem_gnt_i;

   // Stale responses are always older than live ones, so they are consumed
   // first. A response with nothing owed (e.g. after rst) is ignored.
   assign rsp_drop = imem_rvalid_i & (drop_q != '0);
   assign rsp_live = imem_rvalid_i & (drop_q == '0) & (out_q != '0);

   assign inst_valid_o = ~b_empty;
   assign inst_pop     = inst_valid_o & inst_ready_i & ~redirect;
   assign {inst_pc_o, inst_o} = b_head;

   always_comb begin
      ce_d   = ChipEnable;
      pc_d   = pc_q;
      out_d  = out_q;
      drop_d = drop_q;

      if (!ce_on)           pc_d = RESET_VEC;
      else if (flush)       pc_d = new_pc;
      else if (branch_take) pc_d = branch_target_i;
      else if (grant)       pc_d = pc_q + ADDR_W'(PC_STEP);

      if (redirect) begin
         // Everything still owed becomes stale. Pending drops are kept so that
         // back-to-back redirects do not let old responses through.
         out_d  = '0;
         drop_d = drop_q + out_q - CW'(rsp_drop | rsp_live);
      end else begin
         out_d  = out_q + CW'(grant) - CW'(rsp_live);
         drop_d = drop_q - CW'(rsp_drop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ce_q   <= ChipDisable;
         pc_q   <= RESET_VEC;
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         ce_q   <= ce_d;
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   // PCs of live outstanding requests, in issue order.
   sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_addr_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (grant),
      .pop_i   (rsp_live),
      .clear_i (redirect),
      .data_i  (pc_q),
      .data_o  (a_head),
      .count_o (a_cnt),
      .full_o  (a_full),
      .empty_o (a_empty)
   );

   // {pc, instruction} pairs waiting for decode.
   sync_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_inst_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rsp_live & ~redirect),
      .pop_i   (inst_pop),
      .clear_i (redirect),
      .data_i  ({a_head, imem_rdata_i}),
      .data_o  (b_head),
      .count_o (b_cnt),
      .full_o  (b_full),
      .empty_o (b_empty)
   );

   logic unused_ok;
   assign unused_ok = &{1'b0, a_cnt, a_full, a_empty, b_full, stall};

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RV    = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        flush = 1'b0;
   logic [31:0] new_pc = '0;
   logic        branch_flag_i = 1'b0;
   logic [31:0] branch_target_i = '0;
   logic        ce_o;
   logic [31:0] pc_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_ready_i = 1'b0;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush           (flush),
      .new_pc          (new_pc),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .ce_o            (ce_o),
      .pc_o            (pc_o),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_gnt_i      (imem_gnt_i),
      .imem_rvalid_i   (imem_rvalid_i),
      .imem_rdata_i    (imem_rdata_i),
      .inst_valid_o    (inst_valid_o),
      .inst_o          (inst_o),
      .inst_pc_o       (inst_pc_o),
      .inst_ready_i    (inst_ready_i)
   );

   // kind: 0 = live, 1 = stale after redirect, 2 = orphaned by reset
   typedef struct { logic [31:0] addr; int kind; int due; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
   typedef struct {
      logic s0; logic fl; logic br; logic [31:0] npc; logic [31:0] tgt; logic g;
      logic exp_req; logic [31:0] exp_pc;
   } vec_t;

   req_t memq[$];          // memory side: every accepted request, in order
   ent_t expq[$];          // what decode should see, in order
   logic [31:0] glog[$];   // addresses of granted requests
   logic [31:0] m_pc = RV;
   logic        m_ce = 1'b0;
   int cyc = 0, total = 0, bad = 0, grants = 0;

   logic        t_rst = 1'b1, t_flush = 1'b0, t_br = 1'b0, t_ready = 1'b1;
   logic [5:0]  t_stall = '0;
   logic [31:0] t_new = '0, t_tgt = '0;
   int gnt_pct = 0, rv_pct = 0, dly_min = 1, dly_max = 1;
   logic s_req;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive at negedge, check and advance the model, then posedge.
   task automatic step();
      logic rv, g, fst, redir, pop, acc;
      int   nlive;
      req_t h;
      @(negedge clk);
      rst = t_rst; stall = t_stall; flush = t_flush; new_pc = t_new;
      branch_flag_i = t_br; branch_target_i = t_tgt; inst_ready_i = t_ready;
      g  = ($urandom_range(0, 99) < gnt_pct);
      rv = (memq.size() > 0) && (memq[0].due <= cyc) && ($urandom_range(0, 99) < rv_pct);
      imem_gnt_i    = g;
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? mem_data(memq[0].addr) : $urandom;
      #1;
      fst = t_stall[0];
      nlive = 0;
      foreach (memq[i]) if (memq[i].kind != 2) nlive++;
      chk("ce_o", ce_o, m_ce);
      chk("pc_o", pc_o, m_pc);
      chk("imem_addr_o", imem_addr_o, m_pc);
      chk("inst_valid_o", inst_valid_o, expq.size() != 0);
      if (expq.size() != 0) begin
         chk("inst_pc_o", inst_pc_o, expq[0].pc);
         chk("inst_o", inst_o, expq[0].data);
      end
      chk("imem_req_o", imem_req_o,
          m_ce && !fst && !t_flush && !t_br && (nlive + expq.size() < DEPTH));
      s_req = imem_req_o;
      acc   = imem_req_o && g;
      redir = m_ce && (t_flush || (t_br && !fst));
      pop   = (expq.size() != 0) && t_ready && !redir;
      if (pop) void'(expq.pop_front());
      if (rv) begin
         h = memq.pop_front();
         if (h.kind == 0 && !redir && !t_rst) expq.push_back('{pc: h.addr, data: mem_data(h.addr)});
      end
      if (redir) begin
         expq.delete();
         foreach (memq[i]) if (memq[i].kind == 0) memq[i].kind = 1;
      end
      if (acc) begin
         grants++;
         glog.push_back(imem_addr_o);
         memq.push_back('{addr: imem_addr_o, kind: (t_rst ? 2 : 0),
                          due: cyc + $urandom_range(dly_min, dly_max)});
      end
      if (!m_ce)               m_pc = RV;
      else if (t_flush)        m_pc = t_new;
      else if (t_br && !fst)   m_pc = t_tgt;
      else if (acc)            m_pc = m_pc + 32'd4;
      if (t_rst) begin
         m_ce = 1'b0;
         m_pc = RV;
         expq.delete();
         foreach (memq[i]) memq[i].kind = 2;
      end else begin
         m_ce = 1'b1;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic quiet();
      t_rst = 1'b0; t_flush = 1'b0; t_br = 1'b0; t_stall = '0; t_ready = 1'b1;
   endtask

   task automatic drain();
      quiet();
      gnt_pct = 0; rv_pct = 100; dly_min = 1; dly_max = 1;
      for (int i = 0; i < 60 && (memq.size() != 0 || expq.size() != 0); i++) step();
      chk("drain_done", memq.size() + expq.size(), 0);
   endtask

   task automatic reset_seq();
      quiet();
      t_rst = 1'b1;
      repeat (3) step();
      t_rst = 1'b0;
      step();
      grants = 0;
      glog.delete();
   endtask

   vec_t vt[9];
   logic        first_seen;
   logic [31:0] first_pc;

   initial begin
      // ---------------- reset and sequential fetch
      quiet();
      t_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_req", s_req, 1'b0);
         chk("rst_ce", ce_o, 1'b0);
         chk("rst_pc", pc_o, RV);
         chk("rst_valid", inst_valid_o, 1'b0);
      end
      t_rst = 1'b0;
      gnt_pct = 100; rv_pct = 100; dly_min = 1; dly_max = 1;
      grants = 0; glog.delete();
      step();
      #1 chk("ce_after_release", ce_o, 1'b1);
      repeat (12) step();
      for (int k = 0; k < 3; k++)
         chk("seq_addr", (glog.size() > k) ? glog[k] : 32'hxxxx_xxxx, RV + 32'(4 * k));

      // ---------------- backpressure: credit limits grants
      drain(); reset_seq();
      gnt_pct = 100; rv_pct = 100; t_ready = 1'b0;
      repeat (20) step();
      chk("bp_grants", grants, DEPTH);
      chk("bp_req_off", s_req, 1'b0);
      t_ready = 1'b1;
      repeat (10) step();
      chk("bp_resume", grants > DEPTH, 1'b1);

      // ---------------- branch with two outstanding
      drain(); reset_seq();
      gnt_pct = 100; rv_pct = 0;
      for (int i = 0; i < 10 && grants < 2; i++) step();
      chk("br_grants", grants, 2);
      gnt_pct = 0; t_br = 1'b1; t_tgt = 32'h0040_0100;
      step();
      t_br = 1'b0; gnt_pct = 100; rv_pct = 100; dly_min = 1; dly_max = 2;
      first_seen = 1'b0; first_pc = '0;
      for (int i = 0; i < 30 && !first_seen; i++) begin
         step();
         #1;
         if (inst_valid_o) begin first_seen = 1'b1; first_pc = inst_pc_o; end
      end
      chk("br_seen", first_seen, 1'b1);
      chk("br_first_pc", first_pc, 32'h0040_0100);

      // ---------------- redirect priority and wrap, table driven
      drain(); reset_seq();
      rv_pct = 0;
      //        s0    fl    br    new_pc         target         gnt   req   pc after
      vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0040_0000};
      vt[1] = '{1'b1, 1'b0, 1'b1, 32'h0,         32'h0040_0100, 1'b0, 1'b0, 32'h0040_0000};
      vt[2] = '{1'b1, 1'b1, 1'b0, 32'h8000_0180, 32'h0,         1'b0, 1'b0, 32'h8000_0180};
      vt[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, 32'h0000_1000};
      vt[4] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_2000, 1'b0, 1'b0, 32'h0000_2000};
      vt[5] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_2004};
      vt[6] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 1'b0, 32'hFFFF_FFFC};
      vt[7] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_0000};
      vt[8] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0000};
      for (int r = 0; r < 9; r++) begin
         t_stall = {5'b0, vt[r].s0}; t_flush = vt[r].fl; t_br = vt[r].br;
         t_new = vt[r].npc; t_tgt = vt[r].tgt; gnt_pct = vt[r].g ? 100 : 0;
         step();
         chk("vec_req", s_req, vt[r].exp_req);
         #1 chk("vec_pc", pc_o, vt[r].exp_pc);
      end

      // ---------------- reset with two outstanding, late responses ignored
      drain(); reset_seq();
      gnt_pct = 100; rv_pct = 0;
      for (int i = 0; i < 10 && grants < 2; i++) step();
      chk("rst_mid_grants", grants, 2);
      gnt_pct = 0; t_rst = 1'b1;
      step();
      t_rst = 1'b0; rv_pct = 100;
      for (int i = 0; i < 8; i++) begin
         step();
         #1 chk("rst_mid_valid", inst_valid_o, 1'b0);
      end

      // ---------------- randomized against the reference model
      drain(); reset_seq();
      gnt_pct = 70; rv_pct = 60; dly_min = 1; dly_max = 3;
      for (int i = 0; i < 3000; i++) begin
         t_stall    = 6'($urandom);
         t_stall[0] = ($urandom_range(0, 99) < 15);
         t_flush    = ($urandom_range(0, 99) < 3);
         t_br       = ($urandom_range(0, 99) < 6);
         t_new      = $urandom & 32'hFFFF_FFFC;
         t_tgt      = $urandom & 32'hFFFF_FFFC;
         t_ready    = ($urandom_range(0, 99) < 65);
         step();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
